// File: rtl/elevator_controller.sv
// Four-floor SCAN elevator car controller with request latching and door timing.
// Optional return-to-floor-0 parking is enabled by defining ELEVATOR_IDLE_HOME_EN.
module elevator_controller #(
  parameter int FLOOR_TICKS = 2,
  parameter int DOOR_TICKS  = 3,
  parameter int HOME_TICKS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] floor_request,
  output logic [1:0] current_floor,
  output logic       door_open,
  output logic [1:0] direction
);

  localparam int TW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cf_q, cf_d;
  logic [3:0]    pend_q, pend_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] dtmr_q, dtmr_d;
  logic          up_q, up_d;
  logic          last_up_q, last_up_d;
  logic          door_q, door_d;
  logic [1:0]    dir_q, dir_d;

  logic [3:0]    pend_now;
  logic [1:0]    nf;
  logic          req_up, req_dn;
  logic          ahead;
  logic          go_up;

`ifdef ELEVATOR_IDLE_HOME_EN
  localparam int HW = (HOME_TICKS > 1) ? $clog2(HOME_TICKS) : 1;
  logic [HW-1:0] home_q, home_d;
  logic          homing_q, homing_d;
  logic          park_ok;
`else
  logic          unused_home;
  assign unused_home = (HOME_TICKS != 0);
`endif

  function automatic logic [3:0] above_mask(input logic [1:0] f);
    unique case (f)
      2'd0:    above_mask = 4'b1110;
      2'd1:    above_mask = 4'b1100;
      2'd2:    above_mask = 4'b1000;
      default: above_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] below_mask(input logic [1:0] f);
    unique case (f)
      2'd0:    below_mask = 4'b0000;
      2'd1:    below_mask = 4'b0001;
      2'd2:    below_mask = 4'b0011;
      default: below_mask = 4'b0111;
    endcase
  endfunction

  // Scheduling: next state, request bookkeeping, timers and output decode.
  always_comb begin
    pend_now  = pend_q | floor_request;
    state_d   = state_q;
    cf_d      = cf_q;
    pend_d    = pend_now;
    tick_d    = tick_q;
    dtmr_d    = dtmr_q;
    up_d      = up_q;
    last_up_d = last_up_q;
    go_up     = last_up_q;
    req_up    = |(pend_now & above_mask(cf_q));
    req_dn    = |(pend_now & below_mask(cf_q));
    // Saturate so the car can never run past either end.
    if (up_q && cf_q != 2'd3) begin
      nf = cf_q + 2'd1;
    end else if (!up_q && cf_q != 2'd0) begin
      nf = cf_q - 2'd1;
    end else begin
      nf = cf_q;
    end
    ahead = up_q ? |(pend_now & above_mask(nf))
                 : |(pend_now & below_mask(nf));
`ifdef ELEVATOR_IDLE_HOME_EN
    homing_d = homing_q;
    park_ok  = (state_q == S_IDLE) && (pend_now == 4'b0000)
               && (cf_q != 2'd0);
    home_d   = park_ok ? home_q + HW'(1) : '0;
    if (homing_q) begin
      ahead = (pend_now == 4'b0000) && (nf != 2'd0);
    end
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pend_now[cf_q]) begin
          state_d      = S_DOOR;
          pend_d[cf_q] = 1'b0;
          dtmr_d       = DW'(DOOR_TICKS - 1);
        end else if (req_up || req_dn) begin
          go_up     = (req_up && req_dn) ? last_up_q : req_up;
          state_d   = S_MOVE;
          tick_d    = '0;
          up_d      = go_up;
          last_up_d = go_up;
`ifdef ELEVATOR_IDLE_HOME_EN
          homing_d  = 1'b0;
        end else if (park_ok && home_q == HW'(HOME_TICKS - 1)) begin
          state_d   = S_MOVE;
          tick_d    = '0;
          up_d      = 1'b0;
          last_up_d = 1'b0;
          homing_d  = 1'b1;
          home_d    = '0;
`endif
        end
      end
      S_MOVE: begin
        if (tick_q == TW'(FLOOR_TICKS - 1)) begin
          cf_d   = nf;
          tick_d = '0;
          if (pend_now[nf]) begin
            state_d    = S_DOOR;
            pend_d[nf] = 1'b0;
            dtmr_d     = DW'(DOOR_TICKS - 1);
          end else if (!ahead) begin
            state_d = S_IDLE;
          end
`ifdef ELEVATOR_IDLE_HOME_EN
          if (!ahead || pend_now[nf]) begin
            homing_d = 1'b0;
          end
`endif
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DOOR: begin
        pend_d[cf_q] = 1'b0;
        if (floor_request[cf_q]) begin
          dtmr_d = DW'(DOOR_TICKS - 1);
        end else if (dtmr_q == '0) begin
          state_d = S_IDLE;
        end else begin
          dtmr_d = dtmr_q - DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    door_d = (state_d == S_DOOR);
    dir_d  = (state_d == S_MOVE) ? (up_d ? 2'b01 : 2'b10) : 2'b00;
  end

  // State, request latch, timers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cf_q      <= 2'd0;
      pend_q    <= 4'b0000;
      tick_q    <= '0;
      dtmr_q    <= '0;
      up_q      <= 1'b1;
      last_up_q <= 1'b1;
      door_q    <= 1'b0;
      dir_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cf_q      <= cf_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      dtmr_q    <= dtmr_d;
      up_q      <= up_d;
      last_up_q <= last_up_d;
      door_q    <= door_d;
      dir_q     <= dir_d;
    end
  end

`ifdef ELEVATOR_IDLE_HOME_EN
  // Idle-parking counter and homing trip flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      home_q   <= '0;
      homing_q <= 1'b0;
    end else begin
      home_q   <= home_d;
      homing_q <= homing_d;
    end
  end
`endif

  assign current_floor = cf_q;
  assign door_open     = door_q;
  assign direction     = dir_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench for elevator_controller: directed table,
// hand-written reset sequence and random traffic against a floor-level model.
module tb_elevator_controller;

  localparam int FT = 2;
  localparam int DT = 3;

  logic       clk;
  logic       reset;
  logic [3:0] floor_request;
  logic [1:0] current_floor;
  logic       door_open;
  logic [1:0] direction;

  int checks;
  int failures;

  elevator_controller #(
    .FLOOR_TICKS(FT),
    .DOOR_TICKS (DT),
    .HOME_TICKS (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .floor_request(floor_request),
    .current_floor(current_floor),
    .door_open    (door_open),
    .direction    (direction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int         cf;
    int         door;
    int         dir;
  } vec_t;

  vec_t tbl[34];

  // Model: a car at floor m_fl, mode 0 parked, 1 travelling, 2 door open.
  int       m_fl;
  int       m_mode;
  int       m_dir;
  int       m_last;
  int       m_leg;
  int       m_door;
  bit [3:0] m_pend;

  task automatic check(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit any_beyond(input bit [3:0] p, input int f,
                                    input int d);
    for (int i = 0; i < 4; i++) begin
      if (p[i] && (i - f) * d > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_fl   = 0;
    m_mode = 0;
    m_dir  = 1;
    m_last = 1;
    m_leg  = 0;
    m_door = 0;
    m_pend = 4'b0000;
  endtask

  task automatic model_step(input bit [3:0] req);
    bit [3:0] p;
    bit       up;
    bit       dn;
    p = m_pend | req;
    case (m_mode)
      0: begin
        if (p[m_fl]) begin
          p[m_fl] = 1'b0;
          m_mode  = 2;
          m_door  = DT;
        end else begin
          up = any_beyond(p, m_fl, 1);
          dn = any_beyond(p, m_fl, -1);
          if (up || dn) begin
            m_dir  = (up && dn) ? m_last : (up ? 1 : -1);
            m_last = m_dir;
            m_mode = 1;
            m_leg  = FT;
          end
        end
      end
      1: begin
        m_leg--;
        if (m_leg == 0) begin
          m_fl += m_dir;
          if (p[m_fl]) begin
            p[m_fl] = 1'b0;
            m_mode  = 2;
            m_door  = DT;
          end else if (any_beyond(p, m_fl, m_dir)) begin
            m_leg = FT;
          end else begin
            m_mode = 0;
          end
        end
      end
      default: begin
        p[m_fl] = 1'b0;
        if (req[m_fl]) begin
          m_door = DT;
        end else begin
          m_door--;
          if (m_door == 0) m_mode = 0;
        end
      end
    endcase
    m_pend = p;
  endtask

  task automatic cyc(input logic [3:0] req);
    @(negedge clk);
    floor_request = req;
    @(posedge clk);
    #1;
    model_step(req);
  endtask

  task automatic check_out(input string n, input int cf, input int dr,
                           input int dir);
    check({n, ".floor"}, int'(current_floor), cf);
    check({n, ".door"}, int'(door_open), dr);
    check({n, ".dir"}, int'(direction), dir);
  endtask

  task automatic check_model(input string n);
    check_out(n, m_fl, (m_mode == 2) ? 1 : 0,
              (m_mode == 1) ? ((m_dir > 0) ? 1 : 2) : 0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    floor_request = 4'b0000;
    reset         = 1'b1;
    model_reset();

    tbl[0]  = '{4'b0100, 0, 0, 1};
    tbl[1]  = '{4'b0100, 0, 0, 1};
    tbl[2]  = '{4'b0000, 1, 0, 1};
    tbl[3]  = '{4'b0000, 1, 0, 1};
    tbl[4]  = '{4'b0000, 2, 1, 0};
    tbl[5]  = '{4'b0000, 2, 1, 0};
    tbl[6]  = '{4'b0000, 2, 1, 0};
    tbl[7]  = '{4'b0000, 2, 0, 0};
    tbl[8]  = '{4'b0001, 2, 0, 2};
    tbl[9]  = '{4'b0001, 2, 0, 2};
    tbl[10] = '{4'b0000, 1, 0, 2};
    tbl[11] = '{4'b0000, 1, 0, 2};
    tbl[12] = '{4'b0000, 0, 1, 0};
    tbl[13] = '{4'b0000, 0, 1, 0};
    tbl[14] = '{4'b0000, 0, 1, 0};
    tbl[15] = '{4'b0000, 0, 0, 0};
    tbl[16] = '{4'b1000, 0, 0, 1};
    tbl[17] = '{4'b0010, 0, 0, 1};
    tbl[18] = '{4'b0000, 1, 1, 0};
    tbl[19] = '{4'b0000, 1, 1, 0};
    tbl[20] = '{4'b0000, 1, 1, 0};
    tbl[21] = '{4'b0000, 1, 0, 0};
    tbl[22] = '{4'b0000, 1, 0, 1};
    tbl[23] = '{4'b0000, 1, 0, 1};
    tbl[24] = '{4'b0000, 2, 0, 1};
    tbl[25] = '{4'b0000, 2, 0, 1};
    tbl[26] = '{4'b0000, 3, 1, 0};
    tbl[27] = '{4'b0000, 3, 1, 0};
    tbl[28] = '{4'b1000, 3, 1, 0};
    tbl[29] = '{4'b0000, 3, 1, 0};
    tbl[30] = '{4'b0000, 3, 1, 0};
    tbl[31] = '{4'b0000, 3, 0, 0};
    tbl[32] = '{4'b0000, 3, 0, 0};
    tbl[33] = '{4'b0000, 3, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(4'b0000);
      check_out($sformatf("hold%0d", i), 0, 0, 0);
    end

    for (int i = 0; i < 34; i++) begin
      cyc(tbl[i].req);
      check_out($sformatf("vec%0d", i), tbl[i].cf, tbl[i].door,
                tbl[i].dir);
    end

    // Reset while travelling down from floor 3 toward floor 2.
    cyc(4'b0100);
    check_out("rst_move", 3, 0, 2);
    cyc(4'b0000);
    check_out("rst_move2", 3, 0, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_out("rst_async", 0, 0, 0);
    @(posedge clk);
    #1;
    check_out("rst_held", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0000);
      check_out($sformatf("rst_after%0d", i), 0, 0, 0);
    end

    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15))
                                       : 4'b0000;
      cyc(r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
